spi_acl_sequencer: RTL and testbench
====================================

// Module: spi_acl_sequencer
// PURPOSE
// - Hardware bus master that runs complete PmodACL2 (ADXL362) register transactions through the SPI register block.
// - Replaces PicoBlaze polling: drives the same port_id/strobe bus, configures SPCR/SPER once after reset, frames chip select,
//   pushes cmd/addr/data bytes, polls SPSR and pops received bytes.
// - Sits between the sensor-read logic and the SPI register block; one transaction at a time.
// PARAMETERS
// - BASE_ADDRESS  8'h00  SPI register base: +0 SPCR, +1 SPER, +2 SPSR, +3 SPDR (write = TX FIFO push, read = RX FIFO pop)
// - SPCR_INIT     8'h50  SPCR value written after reset (core enable, master, mode 0)
// - SPER_INIT     8'h00  SPER value written after reset
// - POLL_LIMIT    255    max SPSR polls per byte before timeout (8-bit counter)
// PORTS
// - clk        in   1  system clock
// - reset      in   1  synchronous, active-high reset
// - start      in   1  pulse: begin transaction (ignored unless busy=0 and cfg_done=1)
// - cmd        in   8  ADXL362 command: 8'h0A write, 8'h0B read (sampled on start)
// - addr       in   8  first register address (sampled on start)
// - len        in   4  data bytes 1..15; 0 treated as 1 (sampled on start)
// - wdata      in   8  data byte sent in every data phase of a write (sampled on start)
// - busy       out  1  transaction or configuration in progress
// - done       out  1  one-cycle pulse at end of transaction
// - timeout    out  1  sticky: a byte exceeded POLL_LIMIT; cleared by next accepted start
// - rx_data    out  8  received data-phase byte
// - rx_valid   out  1  one-cycle pulse, rx_data valid (data phases only; cmd/addr echoes discarded)
// - cs_n       out  1  ADXL362 chip select, active low
// - port_id    out  8  register bus address
// - out_port   out  8  register bus write data
// - write_strobe out 1 register bus write
// - read_strobe  out 1 register bus read
// - in_port    in   8  register bus read data; registered by the SPI block, valid 1 cycle after port_id is driven
// BEHAVIOUR
// - Reset: busy=1, done=0, timeout=0, rx_data=0, rx_valid=0, cs_n=1, port_id=0, out_port=0, strobes=0, cfg_done=0;
//   reset mid-transaction aborts immediately, cs_n=1 next cycle, RX FIFO contents not drained.
// - States: CFG_SPCR -> CFG_SPER -> IDLE -> SEL -> PUSH -> POLL -> CHK -> POP -> GET -> (PUSH | DESEL) -> IDLE.
// - CFG_SPCR/CFG_SPER: one write_strobe each with SPCR_INIT/SPER_INIT; then cfg_done=1, busy=0 in IDLE.
// - IDLE + start: latch inputs, byte_cnt = len+2 (cmd, addr, data), clear timeout, busy=1, go to SEL.
// - SEL: cs_n=0 for one cycle before the first push (CS setup).
// - PUSH: port_id=BASE+3, write_strobe=1 one cycle; byte order cmd, addr, then data (wdata if cmd=8'h0A, else 8'h00).
// - POLL: port_id=BASE+2, read_strobe=1; CHK samples in_port next cycle. SPSR bit0 = RFEMPTY.
//   RFEMPTY=1 -> poll_cnt++ and back to POLL; poll_cnt == POLL_LIMIT -> set timeout, go to DESEL.
// - POP: port_id=BASE+3, read_strobe=1 (one FIFO pop); GET samples in_port the following cycle.
// - GET: if byte index >= 2, rx_data=in_port and rx_valid=1 for that cycle; byte_cnt--, poll_cnt=0;
//   byte_cnt==0 -> DESEL else PUSH.
// - DESEL: cs_n=1, done=1 for one cycle, busy=0, return to IDLE.
// - Exactly one byte is in flight at a time; TX/RX FIFOs never hold more than one entry (no overflow, WCOL never set).
// - Strobes are single-cycle and never asserted together; port_id/out_port held stable while a strobe is high.
// - start while busy=1 ignored (not queued). start in the same cycle as done is ignored.
// - Per-byte minimum latency: PUSH+POLL+CHK+POP+GET = 5 cycles plus SPI shift time.
// - len=0 behaves as len=1; maximum transaction 17 bytes on the wire.
// TESTING
// - Reset release -> writes SPCR=8'h50 at BASE+0, then SPER=8'h00 at BASE+1, busy falls, cs_n=1.
// - Read len=2, cmd=8'h0B addr=8'h00, model returns AD,1D -> four SPDR pushes (0B,00,00,00), rx_valid twice with 8'hAD,8'h1D, one done.
// - Write len=1 cmd=8'h0A addr=8'h2D wdata=8'h02 -> pushes 0A,2D,02, no rx_valid, cs_n low through last pop.
// - Model holds RFEMPTY=1 for 300 polls -> timeout=1 after 255 polls, cs_n=1, done pulse; next start clears timeout.
// - start asserted while busy and on the done cycle -> no second transaction, port_id traffic unchanged.
// - reset asserted mid data phase -> cs_n=1 and strobes=0 next cycle, config sequence replays.

Source files
------------

// File: rtl/spi_acl_sequencer.sv
// Register-bus master that configures the SPI block once after reset and then runs
// complete ADXL362 transactions (cmd, addr, data bytes) one byte in flight at a time.
module spi_acl_sequencer #(
    parameter logic [7:0] BASE_ADDRESS = 8'h00,
    parameter logic [7:0] SPCR_INIT    = 8'h50,
    parameter logic [7:0] SPER_INIT    = 8'h00,
    parameter int         POLL_LIMIT   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [7:0] addr,
    input  logic [3:0] len,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       cs_n,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    output logic       write_strobe,
    output logic       read_strobe,
    input  logic [7:0] in_port
);

    localparam logic [7:0] SPCR_ADDR = BASE_ADDRESS;
    localparam logic [7:0] SPER_ADDR = BASE_ADDRESS + 8'd1;
    localparam logic [7:0] SPSR_ADDR = BASE_ADDRESS + 8'd2;
    localparam logic [7:0] SPDR_ADDR = BASE_ADDRESS + 8'd3;
    localparam logic [7:0] POLL_MAX  = 8'(POLL_LIMIT - 1);
    localparam logic [7:0] WRITE_CMD = 8'h0A;

    typedef enum logic [3:0] {
        CFG_SPCR, CFG_SPER, IDLE, SEL, PUSH, POLL, CHK, POP, GET, DESEL
    } state_t;

    state_t     state, state_next;
    logic       cfg_done;
    logic [7:0] cmd_q, addr_q, wdata_q;
    logic [4:0] byte_idx, last_idx;
    logic [7:0] poll_cnt;
    logic [7:0] tx_byte;
    logic [3:0] eff_len;
    logic       accept;

    assign eff_len = (len == 4'd0) ? 4'd1 : len;
    assign accept  = (state == IDLE) && start && cfg_done;

    always_ff @(posedge clk) begin
        if (reset) state <= CFG_SPCR;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            CFG_SPCR: state_next = CFG_SPER;
            CFG_SPER: state_next = IDLE;
            IDLE:     if (accept) state_next = SEL;
            SEL:      state_next = PUSH;
            PUSH:     state_next = POLL;
            POLL:     state_next = CHK;
            CHK: begin
                if (!in_port[0])            state_next = POP;
                else if (poll_cnt == POLL_MAX) state_next = DESEL;
                else                        state_next = POLL;
            end
            POP:      state_next = GET;
            GET:      state_next = (byte_idx == last_idx) ? DESEL : PUSH;
            DESEL:    state_next = IDLE;
            default:  state_next = CFG_SPCR;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_done <= 1'b0;
            cmd_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            byte_idx <= '0;
            last_idx <= '0;
            poll_cnt <= '0;
            timeout  <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                CFG_SPER: cfg_done <= 1'b1;
                IDLE: if (accept) begin
                    cmd_q    <= cmd;
                    addr_q   <= addr;
                    wdata_q  <= wdata;
                    byte_idx <= '0;
                    last_idx <= 5'(eff_len) + 5'd1;
                    poll_cnt <= '0;
                    timeout  <= 1'b0;
                end
                CHK: if (in_port[0]) begin
                    if (poll_cnt == POLL_MAX) timeout  <= 1'b1;
                    else                      poll_cnt <= poll_cnt + 8'd1;
                end
                GET: begin
                    // Write transactions clock back nothing meaningful during data phases.
                    if (byte_idx >= 5'd2 && cmd_q != WRITE_CMD) begin
                        rx_data  <= in_port;
                        rx_valid <= 1'b1;
                    end
                    byte_idx <= byte_idx + 5'd1;
                    poll_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_byte = (cmd_q == WRITE_CMD) ? wdata_q : 8'h00;
        if (byte_idx == 5'd0)      tx_byte = cmd_q;
        else if (byte_idx == 5'd1) tx_byte = addr_q;
    end

    always_comb begin
        port_id      = 8'h00;
        out_port     = 8'h00;
        write_strobe = 1'b0;
        read_strobe  = 1'b0;
        cs_n         = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state)
            CFG_SPCR: begin cs_n = 1'b1; port_id = SPCR_ADDR; out_port = SPCR_INIT; write_strobe = 1'b1; end
            CFG_SPER: begin cs_n = 1'b1; port_id = SPER_ADDR; out_port = SPER_INIT; write_strobe = 1'b1; end
            IDLE:     begin cs_n = 1'b1; busy = 1'b0; end
            PUSH:     begin port_id = SPDR_ADDR; out_port = tx_byte; write_strobe = 1'b1; end
            POLL:     begin port_id = SPSR_ADDR; read_strobe = 1'b1; end
            CHK:      port_id = SPSR_ADDR;
            POP:      begin port_id = SPDR_ADDR; read_strobe = 1'b1; end
            GET:      port_id = SPDR_ADDR;
            DESEL:    begin cs_n = 1'b1; busy = 1'b0; done = 1'b1; end
            default:  ;
        endcase
        // NOTE: bus outputs are forced idle while reset is held so no strobe leaks out of the reset state.
        if (reset) begin
            port_id      = 8'h00;
            out_port     = 8'h00;
            write_strobe = 1'b0;
            read_strobe  = 1'b0;
            cs_n         = 1'b1;
            busy         = 1'b1;
            done         = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_acl_sequencer.sv
// Bench: SPI register-block responder plus a transaction-level scoreboard of expected
// bus writes and received bytes for spi_acl_sequencer.
module tb_spi_acl_sequencer;

    localparam logic [7:0] SPSR = 8'h02;
    localparam logic [7:0] SPDR = 8'h03;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cmd = 8'h00, addr = 8'h00, wdata = 8'h00, in_port = 8'h00;
    logic [3:0] len = 4'd0;
    logic       busy, done, timeout, rx_valid, cs_n, write_strobe, read_strobe;
    logic [7:0] rx_data, port_id, out_port;

    spi_acl_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .addr(addr), .len(len),
        .wdata(wdata), .busy(busy), .done(done), .timeout(timeout), .rx_data(rx_data),
        .rx_valid(rx_valid), .cs_n(cs_n), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // SPI block responder state
    logic [7:0] rx_q[$];
    logic [7:0] miso_q[$];
    int         shift_cnt = 0;
    int         shift_delay = 1;
    bit         stall = 1'b0;
    int         spsr_reads = 0;

    // Scoreboard state
    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_rx_q[$];
    logic [7:0]  got_rx[$];
    int          done_cnt = 0, pushes = 0, cycle = 0, last_push_cycle = 0, last_gap = 0;

    always @(negedge clk) begin
        if (reset) begin
            rx_q.delete();
            shift_cnt = 0;
            in_port   = 8'h00;
        end else begin
            if (shift_cnt > 0) begin
                shift_cnt--;
                if (shift_cnt == 0) rx_q.push_back(miso_q.size() != 0 ? miso_q.pop_front() : 8'hEE);
            end
            if (write_strobe && port_id == SPDR) begin
                check("fifo_single_entry", rx_q.size() + shift_cnt, 0);
                if (!stall) shift_cnt = shift_delay;
            end
            if (read_strobe && port_id == SPSR) begin
                spsr_reads++;
                in_port = {7'b0, rx_q.size() == 0};
            end
            if (read_strobe && port_id == SPDR) begin
                check("pop_nonempty", rx_q.size() != 0, 1);
                in_port = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
            end
        end
    end

    always @(negedge clk) begin
        cycle++;
        if (!reset) begin
            if (write_strobe) begin
                check("strobe_exclusive", read_strobe, 0);
                check("write_expected", exp_wr_q.size() != 0, 1);
                if (exp_wr_q.size() != 0) check("bus_write", {port_id, out_port}, exp_wr_q.pop_front());
                if (port_id == SPDR) begin
                    pushes++;
                    last_gap = cycle - last_push_cycle;
                    last_push_cycle = cycle;
                end
            end
            if ((write_strobe || read_strobe) && port_id == SPDR) check("cs_low_on_spdr", cs_n, 0);
            if (rx_valid) begin
                got_rx.push_back(rx_data);
                check("rx_expected", exp_rx_q.size() != 0, 1);
                if (exp_rx_q.size() != 0) check("rx_data", rx_data, exp_rx_q.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Builds the expected bus writes / received bytes from the transaction rules, then issues start.
    task automatic launch(input logic [7:0] c, input logic [7:0] a, input logic [3:0] l, input logic [7:0] w);
        int n;
        n = (l == 4'd0) ? 1 : int'(l);
        exp_wr_q.push_back({SPDR, c});
        exp_wr_q.push_back({SPDR, a});
        for (int i = 0; i < n; i++) exp_wr_q.push_back({SPDR, (c == 8'h0A) ? w : 8'h00});
        if (c != 8'h0A)
            for (int i = 2; i < miso_q.size(); i++) exp_rx_q.push_back(miso_q[i]);
        tick(1);
        cmd = c; addr = a; len = l; wdata = w; start = 1'b1;
        tick(1);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("timeout_cleared_on_start", timeout, 0);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic finish_txn(input int exp_done);
        tick(1);
        check("writes_consumed", exp_wr_q.size(), 0);
        check("rx_consumed", exp_rx_q.size(), 0);
        check("idle_busy", busy, 0);
        check("idle_cs_n", cs_n, 1);
        check("done_count", done_cnt, exp_done);
    endtask

    task automatic run_config();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cfg_cycles", n, 3);
        check("cfg_writes_consumed", exp_wr_q.size(), 0);
        check("cfg_cs_n", cs_n, 1);
        tick(1);
    endtask

    initial begin
        int n, p0;
        tick(3);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_port_id", port_id, 0);
        check("rst_out_port", out_port, 0);
        check("rst_strobes", {write_strobe, read_strobe}, 0);

        exp_wr_q.push_back(16'h0050);
        exp_wr_q.push_back(16'h0100);
        reset = 1'b0;
        run_config();

        // Read len=2 from 0x00; sensor answers AD,1D in the data phases
        shift_delay = 1;
        miso_q = '{8'h11, 8'h22, 8'hAD, 8'h1D};
        p0 = pushes;
        launch(8'h0B, 8'h00, 4'd2, 8'h00);
        wait_done(200);
        finish_txn(1);
        check("read_push_count", pushes - p0, 4);
        check("read_rx_count", got_rx.size(), 2);
        if (got_rx.size() >= 2) begin
            check("read_rx0_literal", got_rx[0], 8'hAD);
            check("read_rx1_literal", got_rx[1], 8'h1D);
        end
        check("byte_latency_min", last_gap, 5);

        // Write 0x02 to register 0x2D
        shift_delay = 2;
        miso_q = '{8'h00, 8'h00, 8'h00};
        p0 = pushes;
        launch(8'h0A, 8'h2D, 4'd1, 8'h02);
        wait_done(200);
        finish_txn(2);
        check("write_push_count", pushes - p0, 3);
        check("write_no_rx", got_rx.size(), 2);
        check("byte_latency_shift2", last_gap, 7);

        // Sensor never answers: timeout after the poll budget
        stall = 1'b1;
        spsr_reads = 0;
        miso_q.delete();
        exp_wr_q.push_back({SPDR, 8'h0B});
        tick(1);
        cmd = 8'h0B; addr = 8'h00; len = 4'd1; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(2000);
        tick(1);
        check("timeout_set", timeout, 1);
        check("timeout_poll_count", spsr_reads, 255);
        check("timeout_cs_n", cs_n, 1);
        check("timeout_busy", busy, 0);
        check("timeout_done_count", done_cnt, 3);
        check("timeout_no_extra_writes", exp_wr_q.size(), 0);
        stall = 1'b0;

        // len=0 behaves as one data byte; this start clears timeout
        shift_delay = 1;
        miso_q = '{8'h00, 8'h00, 8'h5A};
        p0 = pushes;
        launch(8'h0B, 8'h08, 4'd0, 8'h00);
        wait_done(200);
        finish_txn(4);
        check("len0_push_count", pushes - p0, 3);
        check("len0_rx_literal", got_rx[got_rx.size() - 1], 8'h5A);

        // start while busy and on the done cycle are both ignored
        miso_q = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        p0 = pushes;
        launch(8'h0B, 8'h10, 4'd3, 8'h00);
        tick(4);
        cmd = 8'h0A; addr = 8'h77; start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(300);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tick(30);
        check("ignored_start_busy", busy, 0);
        check("ignored_start_done_count", done_cnt, 5);
        check("ignored_start_push_count", pushes - p0, 5);
        check("ignored_start_no_writes", exp_wr_q.size(), 0);

        // Reset during a data phase aborts and replays configuration
        miso_q = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        n = got_rx.size();
        launch(8'h0B, 8'h20, 4'd4, 8'h00);
        p0 = 0;
        while (got_rx.size() == n && p0 < 200) begin
            @(negedge clk);
            p0++;
        end
        check("mid_data_reached", got_rx.size() > n, 1);
        tick(1);
        reset = 1'b1;
        exp_wr_q.delete();
        exp_rx_q.delete();
        miso_q.delete();
        @(negedge clk);
        check("abort_cs_n", cs_n, 1);
        check("abort_strobes", {write_strobe, read_strobe}, 0);
        check("abort_busy", busy, 1);
        tick(2);
        exp_wr_q.push_back(16'h0050);
        exp_wr_q.push_back(16'h0100);
        reset = 1'b0;
        run_config();
        check("abort_no_done", done_cnt, 5);

        // Normal read after the replayed configuration
        miso_q = '{8'h00, 8'h00, 8'hC3};
        launch(8'h0B, 8'h0E, 4'd1, 8'h00);
        wait_done(200);
        finish_txn(6);
        check("post_reset_rx_literal", got_rx[got_rx.size() - 1], 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
